// File: rtl/uart_pkg.sv
// Shared definitions for the UART buffer: FSM state encodings and byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    T_IDLE   = 2'b00,
    T_LOAD   = 2'b01,
    T_STROBE = 2'b10,
    T_BUSY   = 2'b11
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_ACK  = 2'b01,
    R_WAIT = 2'b10
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a combinational
// head output read straight from storage. Storage itself is not reset.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BYTE_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] CAPACITY = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is simply dropped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CAPACITY);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write; left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count moves only when exactly one side acts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffer.sv
// CPU-side TX/RX byte buffering in front of a simple UART. The TX FSM drains
// the TX FIFO into the UART with a one-cycle write strobe; the RX FSM captures
// each new UART byte, acknowledges it with a read pulse and queues it.
module uart_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_wdata,
  input  logic          tx_push,
  output logic          tx_full,
  output logic [AW:0]   tx_count,
  output logic [7:0]    rx_rdata,
  input  logic          rx_pop,
  output logic          rx_empty,
  output logic [AW:0]   rx_count,
  output logic          rx_ovr,
  input  logic          ovr_clr,
  output logic [7:0]    u_tx_data,
  output logic          u_write,
  input  logic          u_tx_ready,
  input  logic [7:0]    u_rx_data,
  input  logic          u_rx_new,
  output logic          u_read
);

  tx_state_t  tx_state;
  tx_state_t  tx_next;
  rx_state_t  rx_state;
  rx_state_t  rx_next;

  logic [7:0] tx_head;
  logic       tx_empty;
  logic       tx_pop;
  logic [7:0] rx_byte;
  logic       rx_push;
  logic       rx_full;
  logic       rx_capture;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (tx_wdata),
    .push  (tx_push),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (rx_byte),
    .push  (rx_push),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // TX state register; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  // TX sequencing: pop on leaving idle, strobe write, then wait out the UART busy period.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    u_write = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty && u_tx_ready) begin
          tx_pop  = 1'b1;
          tx_next = T_LOAD;
        end
      end
      T_LOAD: begin
        tx_next = T_STROBE;
      end
      T_STROBE: begin
        u_write = 1'b1;
        if (!u_tx_ready) begin
          tx_next = T_BUSY;
        end
      end
      T_BUSY: begin
        if (u_tx_ready) begin
          tx_next = T_IDLE;
        end
      end
      default: begin
        tx_next = T_IDLE;
      end
    endcase
  end

  // Outgoing byte is latched at the pop and held until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_tx_data <= '0;
    end else if (tx_pop) begin
      u_tx_data <= tx_head;
    end
  end

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  // RX sequencing: capture, acknowledge and enqueue for one cycle, then wait for rx_new to drop.
  always_comb begin
    rx_next    = rx_state;
    rx_capture = 1'b0;
    rx_push    = 1'b0;
    u_read     = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (u_rx_new) begin
          rx_capture = 1'b1;
          rx_next    = R_ACK;
        end
      end
      R_ACK: begin
        u_read  = 1'b1;
        rx_push = 1'b1;
        rx_next = R_WAIT;
      end
      R_WAIT: begin
        if (!u_rx_new) begin
          rx_next = R_IDLE;
        end
      end
      default: begin
        rx_next = R_IDLE;
      end
    endcase
  end

  // Holding register for the byte being acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte <= '0;
    end else if (rx_capture) begin
      rx_byte <= u_rx_data;
    end
  end

  // Sticky overrun: a dropped byte wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovr <= 1'b0;
    end else if (rx_push && rx_full) begin
      rx_ovr <= 1'b1;
    end else if (ovr_clr) begin
      rx_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_buffer.sv
// Self-checking bench for uart_buffer: a behavioural UART on the far side,
// queue-based models of both FIFOs and the overrun flag.
module tb_uart_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tx_wdata;
  logic          tx_push;
  logic          tx_full;
  logic [AW:0]   tx_count;
  logic [7:0]    rx_rdata;
  logic          rx_pop;
  logic          rx_empty;
  logic [AW:0]   rx_count;
  logic          rx_ovr;
  logic          ovr_clr;
  logic [7:0]    u_tx_data;
  logic          u_write;
  logic          u_tx_ready;
  logic [7:0]    u_rx_data;
  logic          u_rx_new;
  logic          u_read;

  int         total = 0;
  int         bad = 0;
  int         write_pulses = 0;
  int         read_pulses = 0;
  logic       write_prev = 1'b0;
  bit         tx_model_on = 1'b0;
  bit         rx_model_on = 1'b0;
  int         busy_left = 0;
  logic [7:0] sent_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_q[$];
  bit         ovr_m = 1'b0;

  uart_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_wdata   (tx_wdata),
    .tx_push    (tx_push),
    .tx_full    (tx_full),
    .tx_count   (tx_count),
    .rx_rdata   (rx_rdata),
    .rx_pop     (rx_pop),
    .rx_empty   (rx_empty),
    .rx_count   (rx_count),
    .rx_ovr     (rx_ovr),
    .ovr_clr    (ovr_clr),
    .u_tx_data  (u_tx_data),
    .u_write    (u_write),
    .u_tx_ready (u_tx_ready),
    .u_rx_data  (u_rx_data),
    .u_rx_new   (u_rx_new),
    .u_read     (u_read)
  );

  always #5 clk = ~clk;

  // One clock, then let the behavioural UART react to what the DUT shows.
  task automatic clk_step();
    @(posedge clk);
    #1;
    if (tx_model_on) begin
      if (u_write && !write_prev) begin
        write_pulses++;
        sent_q.push_back(u_tx_data);
      end
      if (u_write && u_tx_ready) begin
        u_tx_ready = 1'b0;
        busy_left  = $urandom_range(1, 4);
      end else if (!u_tx_ready) begin
        if (busy_left > 0) busy_left--;
        else u_tx_ready = 1'b1;
      end
    end
    write_prev = u_write;
    if (rx_model_on && u_read) begin
      read_pulses++;
      u_rx_new = 1'b0;
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wdata = b;
    tx_push  = 1'b1;
    clk_step();
    tx_push  = 1'b0;
  endtask

  task automatic wait_tx_drained(input int n, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (sent_q.size() >= n && tx_count == '0 && !u_write && u_tx_ready) break;
      clk_step();
    end
    total++;
    if (i >= limit) begin
      bad++;
      $display("[TB] FAIL tx_drain_timeout: got %0d bytes want %0d", sent_q.size(), n);
    end
    repeat (4) clk_step();
  endtask

  task automatic send_rx_byte(input logic [7:0] b, input bit pop_at_ack, input bit clr_at_ack);
    int  r0;
    bit  full_before;
    r0 = read_pulses;
    u_rx_data = b;
    u_rx_new  = 1'b1;
    for (int i = 0; i < 10 && read_pulses == r0; i++) clk_step();
    total++;
    if (read_pulses == r0) begin
      bad++;
      $display("[TB] FAIL rx_read_timeout: got 0 pulses want 1");
      u_rx_new = 1'b0;
      return;
    end
    full_before = (rx_q.size() == DEPTH);
    rx_pop  = pop_at_ack;
    ovr_clr = clr_at_ack;
    clk_step();
    rx_pop  = 1'b0;
    ovr_clr = 1'b0;
    if (pop_at_ack && rx_q.size() > 0) void'(rx_q.pop_front());
    if (full_before) begin
      ovr_m = 1'b1;
    end else begin
      rx_q.push_back(b);
      if (clr_at_ack) ovr_m = 1'b0;
    end
    clk_step();
    total++;
    if (read_pulses - r0 != 1) begin
      bad++;
      $display("[TB] FAIL rx_read_pulses: got %0d want 1", read_pulses - r0);
    end
  endtask

  task automatic pop_rx();
    if (rx_q.size() > 0) begin
      total++;
      if (rx_rdata !== rx_q[0]) begin
        bad++;
        $display("[TB] FAIL rx_head: got %02h want %02h", rx_rdata, rx_q[0]);
      end
    end
    rx_pop = 1'b1;
    clk_step();
    rx_pop = 1'b0;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
    total++;
    if (rx_empty !== (rx_q.size() == 0)) begin
      bad++;
      $display("[TB] FAIL rx_empty: got %0b want %0b", rx_empty, rx_q.size() == 0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (tx_full !== 1'b0)  begin bad++; $display("[TB] FAIL reset_tx_full: got %0b want 0", tx_full); end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_rx_empty: got %0b want 1", rx_empty); end
    total++; if (rx_ovr !== 1'b0)   begin bad++; $display("[TB] FAIL reset_rx_ovr: got %0b want 0", rx_ovr); end
    total++; if (u_write !== 1'b0)  begin bad++; $display("[TB] FAIL reset_u_write: got %0b want 0", u_write); end
    total++; if (u_read !== 1'b0)   begin bad++; $display("[TB] FAIL reset_u_read: got %0b want 0", u_read); end
    total++; if (u_tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_u_tx_data: got %02h want 00", u_tx_data); end
    total++; if (tx_count !== '0)   begin bad++; $display("[TB] FAIL reset_tx_count: got %0d want 0", tx_count); end
    total++; if (rx_count !== '0)   begin bad++; $display("[TB] FAIL reset_rx_count: got %0d want 0", rx_count); end
    rst = 1'b0;
    clk_step();
  endtask

  task automatic test_tx_order();
    int p0;
    tx_model_on = 1'b1;
    rx_model_on = 1'b1;
    u_tx_ready  = 1'b1;
    repeat (2) clk_step();
    sent_q.delete();
    p0 = write_pulses;
    push_tx(8'h41);
    total++; if (tx_count !== 5'd1) begin bad++; $display("[TB] FAIL order_count_after_push: got %0d want 1", tx_count); end
    total++; if (u_write !== 1'b0)  begin bad++; $display("[TB] FAIL order_write_early1: got %0b want 0", u_write); end
    push_tx(8'h42);
    total++; if (tx_count !== 5'd1) begin bad++; $display("[TB] FAIL order_count_push_pop: got %0d want 1", tx_count); end
    total++; if (u_write !== 1'b0)  begin bad++; $display("[TB] FAIL order_write_early2: got %0b want 0", u_write); end
    total++; if (u_tx_data !== 8'h41) begin bad++; $display("[TB] FAIL order_load_data: got %02h want 41", u_tx_data); end
    clk_step();
    total++; if (u_write !== 1'b1)  begin bad++; $display("[TB] FAIL order_latency: got %0b want 1", u_write); end
    wait_tx_drained(2, 100);
    repeat (10) clk_step();
    total++; if (sent_q.size() != 2) begin bad++; $display("[TB] FAIL order_nbytes: got %0d want 2", sent_q.size()); end
    total++; if (write_pulses - p0 != 2) begin bad++; $display("[TB] FAIL order_pulses: got %0d want 2", write_pulses - p0); end
    if (sent_q.size() >= 2) begin
      total++; if (sent_q[0] !== 8'h41) begin bad++; $display("[TB] FAIL order_byte0: got %02h want 41", sent_q[0]); end
      total++; if (sent_q[1] !== 8'h42) begin bad++; $display("[TB] FAIL order_byte1: got %02h want 42", sent_q[1]); end
    end
  endtask

  task automatic test_tx_random();
    int n;
    int p0;
    logic [7:0] b;
    sent_q.delete();
    tx_exp.delete();
    p0 = write_pulses;
    n  = $urandom_range(4, 10);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      tx_exp.push_back(b);
      push_tx(b);
      repeat ($urandom_range(0, 3)) clk_step();
    end
    wait_tx_drained(n, 400);
    total++; if (sent_q.size() != n) begin bad++; $display("[TB] FAIL rand_nbytes: got %0d want %0d", sent_q.size(), n); end
    total++; if (write_pulses - p0 != n) begin bad++; $display("[TB] FAIL rand_pulses: got %0d want %0d", write_pulses - p0, n); end
    for (int i = 0; i < n && i < sent_q.size(); i++) begin
      total++;
      if (sent_q[i] !== tx_exp[i]) begin
        bad++;
        $display("[TB] FAIL rand_byte%0d: got %02h want %02h", i, sent_q[i], tx_exp[i]);
      end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] b;
    tx_model_on = 1'b0;
    u_tx_ready  = 1'b0;
    clk_step();
    tx_exp.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) tx_exp.push_back(b);
      push_tx(b);
      if (i == DEPTH - 2) begin
        total++; if (tx_full !== 1'b0) begin bad++; $display("[TB] FAIL full_early: got %0b want 0", tx_full); end
      end
      if (i >= DEPTH - 1) begin
        total++; if (tx_full !== 1'b1) begin bad++; $display("[TB] FAIL full_flag%0d: got %0b want 1", i + 1, tx_full); end
        total++; if (tx_count !== 5'd16) begin bad++; $display("[TB] FAIL full_count%0d: got %0d want 16", i + 1, tx_count); end
      end
    end
    sent_q.delete();
    write_prev  = u_write;
    tx_model_on = 1'b1;
    u_tx_ready  = 1'b1;
    wait_tx_drained(DEPTH, 400);
    total++; if (sent_q.size() != DEPTH) begin bad++; $display("[TB] FAIL full_drain_n: got %0d want %0d", sent_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < sent_q.size(); i++) begin
      total++;
      if (sent_q[i] !== tx_exp[i]) begin
        bad++;
        $display("[TB] FAIL full_drain_byte%0d: got %02h want %02h", i, sent_q[i], tx_exp[i]);
      end
    end
  endtask

  task automatic test_rx_single();
    send_rx_byte(8'h5A, 1'b0, 1'b0);
    total++; if (rx_empty !== 1'b0) begin bad++; $display("[TB] FAIL rx1_empty: got %0b want 0", rx_empty); end
    total++; if (rx_rdata !== 8'h5A) begin bad++; $display("[TB] FAIL rx1_data: got %02h want 5a", rx_rdata); end
    total++; if (rx_count !== 5'd1) begin bad++; $display("[TB] FAIL rx1_count: got %0d want 1", rx_count); end
    pop_rx();
  endtask

  task automatic test_rx_overrun();
    logic [7:0] first;
    logic [7:0] b;
    first = 8'h00;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (i == 0) first = b;
      send_rx_byte(b, 1'b0, 1'b0);
      if (i == DEPTH - 1) begin
        total++; if (rx_ovr !== 1'b0) begin bad++; $display("[TB] FAIL ovr_early: got %0b want 0", rx_ovr); end
      end
    end
    total++; if (rx_ovr !== 1'b1)    begin bad++; $display("[TB] FAIL ovr_set: got %0b want 1", rx_ovr); end
    total++; if (rx_count !== 5'd16) begin bad++; $display("[TB] FAIL ovr_count: got %0d want 16", rx_count); end
    total++; if (rx_rdata !== first) begin bad++; $display("[TB] FAIL ovr_head: got %02h want %02h", rx_rdata, first); end
    ovr_clr = 1'b1;
    clk_step();
    ovr_clr = 1'b0;
    ovr_m   = 1'b0;
    total++; if (rx_ovr !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear: got %0b want 0", rx_ovr); end
    send_rx_byte(8'($urandom), 1'b1, 1'b1);
    total++; if (rx_count !== 5'(rx_q.size())) begin bad++; $display("[TB] FAIL full_push_pop_count: got %0d want %0d", rx_count, rx_q.size()); end
    total++; if (rx_ovr !== ovr_m) begin bad++; $display("[TB] FAIL ovr_priority: got %0b want %0b", rx_ovr, ovr_m); end
    total++; if (rx_rdata !== rx_q[0]) begin bad++; $display("[TB] FAIL full_push_pop_head: got %02h want %02h", rx_rdata, rx_q[0]); end
  endtask

  task automatic test_rx_random();
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        send_rx_byte(8'($urandom), 1'b0, 1'b0);
      end else if (op == 3) begin
        ovr_clr = 1'b1;
        clk_step();
        ovr_clr = 1'b0;
        ovr_m   = 1'b0;
      end else begin
        pop_rx();
      end
      total++; if (rx_count !== 5'(rx_q.size())) begin bad++; $display("[TB] FAIL rxr_count%0d: got %0d want %0d", i, rx_count, rx_q.size()); end
      total++; if (rx_ovr !== ovr_m) begin bad++; $display("[TB] FAIL rxr_ovr%0d: got %0b want %0b", i, rx_ovr, ovr_m); end
    end
  endtask

  task automatic test_reset_mid();
    int i;
    int p0;
    push_tx(8'($urandom));
    for (i = 0; i < 20 && !u_write; i++) clk_step();
    total++; if (u_write !== 1'b1) begin bad++; $display("[TB] FAIL mid_reach_strobe: got %0b want 1", u_write); end
    rst = 1'b1;
    #1;
    total++; if (u_write !== 1'b0)    begin bad++; $display("[TB] FAIL mid_write_drop: got %0b want 0", u_write); end
    total++; if (tx_count !== '0)     begin bad++; $display("[TB] FAIL mid_tx_count: got %0d want 0", tx_count); end
    total++; if (u_tx_data !== 8'h00) begin bad++; $display("[TB] FAIL mid_tx_data: got %02h want 00", u_tx_data); end
    clk_step();
    rst = 1'b0;
    rx_q.delete();
    ovr_m = 1'b0;
    p0 = write_pulses;
    repeat (20) clk_step();
    total++; if (write_pulses != p0) begin bad++; $display("[TB] FAIL mid_no_write: got %0d want 0", write_pulses - p0); end
    sent_q.delete();
    push_tx(8'hC3);
    wait_tx_drained(1, 100);
    total++; if (write_pulses - p0 != 1) begin bad++; $display("[TB] FAIL mid_new_pulse: got %0d want 1", write_pulses - p0); end
    total++; if (sent_q.size() != 1 || sent_q[0] !== 8'hC3) begin bad++; $display("[TB] FAIL mid_new_byte: got %0d bytes want 1 byte c3", sent_q.size()); end
  endtask

  initial begin
    rst        = 1'b1;
    tx_wdata   = 8'h00;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    ovr_clr    = 1'b0;
    u_tx_ready = 1'b0;
    u_rx_data  = 8'h00;
    u_rx_new   = 1'b0;
    test_reset();
    test_tx_order();
    test_tx_random();
    test_tx_full();
    test_rx_single();
    test_rx_overrun();
    test_rx_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
